// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel word handshake in, serial bit stream with framing out
interface bit_serializer_if #(parameter int unsigned WIDTH = 5);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic out;
  logic out_valid;
  logic sof;
  logic eof;
  modport master (output din, din_valid, input din_ready, out, out_valid, sof, eof);
  modport slave (input din, din_valid, output din_ready, out, out_valid, sof, eof);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: shifts WIDTH-bit words out one bit per clock with sof/eof framing
module bit_serializer #(
  parameter int unsigned WIDTH = 5,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  bit_serializer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last, accept;
  logic [WIDTH-1:0] shifted;
  assign last = state_q == SHIFT && cnt_q == CW'(WIDTH - 1);
  assign bus.din_ready = state_q == IDLE || last;
  assign accept = bus.din_valid && bus.din_ready;
  assign shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
  // a new word on the last-bit edge overrides the return to IDLE, giving gapless streams
  always_comb begin
    state_d = accept ? SHIFT : (last ? IDLE : state_q);
    sr_d = accept ? bus.din : (state_q == SHIFT ? shifted : sr_q);
    cnt_d = accept ? '0 : (state_q == SHIFT ? cnt_q + 1'b1 : cnt_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.out_valid = state_q == SHIFT;
  assign bus.out = state_q == SHIFT ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_BIT;
  assign bus.sof = state_q == SHIFT && cnt_q == '0;
  assign bus.eof = last;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: MSB-first/idle-0 and LSB-first/idle-1 serializers checked against a word-level model
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int rem = 0;
  int pos = 0;
  logic [4:0] word = '0;
  bit_serializer_if #(.WIDTH(5)) bus0 ();
  bit_serializer_if #(.WIDTH(5)) bus1 ();
  bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    logic busy;
    busy = rem > 0;
    chk("ready0", 32'(bus0.din_ready), 32'(rem <= 1));
    chk("ready1", 32'(bus1.din_ready), 32'(rem <= 1));
    chk("valid0", 32'(bus0.out_valid), 32'(busy));
    chk("valid1", 32'(bus1.out_valid), 32'(busy));
    chk("sof0", 32'(bus0.sof), 32'(busy && pos == 0));
    chk("sof1", 32'(bus1.sof), 32'(busy && pos == 0));
    chk("eof0", 32'(bus0.eof), 32'(rem == 1));
    chk("eof1", 32'(bus1.eof), 32'(rem == 1));
    chk("out_msb", 32'(bus0.out), busy ? 32'((word >> (4 - pos)) & 5'd1) : 32'd0);
    chk("out_lsb", 32'(bus1.out), busy ? 32'((word >> pos) & 5'd1) : 32'd1);
  endtask
  task automatic step(input logic v, input logic [4:0] d);
    @(negedge clk);
    bus0.din_valid = v;
    bus1.din_valid = v;
    bus0.din = d;
    bus1.din = d;
    #1 check_all();
    @(posedge clk);
    if (v && rem <= 1) begin
      word = d;
      rem = 5;
      pos = 0;
    end else if (rem > 0) begin
      rem--;
      pos++;
    end
  endtask
  initial begin
    bus0.din_valid = 1'b0;
    bus1.din_valid = 1'b0;
    bus0.din = '0;
    bus1.din = '0;
    #1 check_all();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 5'b10010);
    repeat (7) step(1'b0, 5'b11111);
    step(1'b1, 5'b10010);
    repeat (4) step(1'b1, 5'b01000);
    repeat (6) step(1'b0, 5'b00000);
    step(1'b1, 5'b00011);
    repeat (4) step(1'b1, 5'($urandom));
    repeat (7) step(1'b0, 5'($urandom));
    step(1'b1, 5'b10110);
    step(1'b0, 5'b00000);
    step(1'b0, 5'b00000);
    #2 rst_n = 1'b0;
    rem = 0;
    pos = 0;
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 5'b10110);
    step(1'b1, 5'b11001);
    repeat (300) step(($urandom % 4) != 0, 5'($urandom));
    repeat (8) step(1'b0, 5'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the parallel word width; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, giving the value driven on out when no word is being sent.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port din, input, WIDTH bits, the parallel word to be sent.
REQ-007 The block SHALL have port din_valid, input, 1 bit, meaning din holds a word to send.
REQ-008 The block SHALL have port din_ready, output, 1 bit, meaning the block accepts din on this edge.
REQ-009 The block SHALL have port out, output, 1 bit, the serial bit stream fed to the downstream sequence detector's in port.
REQ-010 The block SHALL have port out_valid, output, 1 bit, high while out carries a data bit.
REQ-011 The block SHALL have port sof, output, 1 bit, high during the first bit of each word.
REQ-012 The block SHALL have port eof, output, 1 bit, high during the last bit of each word.

Function
REQ-013 The block SHALL implement a two-state machine, IDLE and SHIFT, with a shift register of WIDTH bits and a bit counter of $clog2(WIDTH) bits.
REQ-014 A word SHALL be accepted on a rising edge where din_valid=1 and din_ready=1; the edge loads din into the shift register, clears the bit counter and enters SHIFT.
REQ-015 din_ready SHALL be combinational and high only in two cases: state is IDLE, or state is SHIFT with bit counter = WIDTH-1.
REQ-016 When din_ready=0, din and din_valid SHALL be ignored; din_valid may deassert at any time without any effect on the block.
REQ-017 Latency: the first bit of a word accepted at edge k SHALL appear on out in the cycle after edge k; the word SHALL occupy exactly WIDTH consecutive cycles.
REQ-018 In SHIFT, out SHALL be the shift register's MSB if MSB_FIRST=1, or its LSB otherwise; each edge in SHIFT SHALL shift toward that end and increment the bit counter.
REQ-019 In IDLE, out SHALL equal IDLE_BIT and out_valid, sof and eof SHALL be 0.
REQ-020 out_valid SHALL be 1 exactly when state is SHIFT.
REQ-021 sof SHALL be 1 when the bit counter = 0 in SHIFT; eof SHALL be 1 when the bit counter = WIDTH-1 in SHIFT.
REQ-022 Back-to-back: on the last-bit edge with din_valid=1, the next word SHALL be loaded and its first bit SHALL follow with no gap; out_valid SHALL stay 1.
REQ-023 On the last-bit edge with din_valid=0, the block SHALL return to IDLE.
REQ-024 out, out_valid, sof and eof SHALL be derived from registered state only, with no combinational path from din or din_valid.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately, without waiting for clk, set state to IDLE, clear the shift register and bit counter, and drive out=IDLE_BIT, out_valid=0, sof=0, eof=0 and din_ready=1.
REQ-026 Reset asserted in the middle of a word SHALL discard the remaining bits; no partial word SHALL resume after reset is released.
REQ-027 The first word SHALL be acceptable on the first rising edge after rst_n deasserts.

Verification
REQ-028 Single word (WIDTH=5, MSB_FIRST=1): din=5'b10010 accepted at one edge -> out=1,0,0,1,0 on the next 5 cycles; sof on the bit-1 cycle; eof on the bit-5 cycle; then out=0 and out_valid=0.
REQ-029 Back-to-back: 5'b10010 followed by 5'b01000 with din_valid held high -> contiguous stream 1001001000, out_valid high for 10 cycles; the downstream detector for 10010 pulses twice.
REQ-030 LSB-first (MSB_FIRST=0): din=5'b00011 -> out=1,1,0,0,0.
REQ-031 Stall: din_valid held high with a new word during cycles 1..4 of a word -> din_ready=0 in those cycles; the word is accepted only at the eof edge; din changes during cycles 1..4 do not change out.
REQ-032 Mid-word reset: rst_n pulled low after 2 bits of 5'b10110 -> out=IDLE_BIT, out_valid=0, din_ready=1 asynchronously; after release, no residual bits appear on out.
REQ-033 IDLE_BIT=1 with no words sent -> out holds 1 and out_valid holds 0 indefinitely.
